// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the BNN stream loader and its classifier wrapper.
package bnn_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Class-index width; kept at least 1 bit so a degenerate C still yields a legal port.
    function automatic int kw_of(input int c);
        return (c > 2) ? $clog2(c) : 1;
    endfunction

    function automatic int cnt_w_of(input int ts);
        return $clog2(ts + 1);
    endfunction

    function automatic int idx_w_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_stream_loader.sv
// Collects a framed stream of B-bit features into a packed vector for a combinational
// BNN classifier, waits Ts cycles for it to settle, then hands the class downstream.
module bnn_stream_loader
    import bnn_pkg::*;
#(
    parameter int N  = 11,
    parameter int B  = 4,
    parameter int C  = 7,
    parameter int Ts = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [B-1:0]          s_data,
    input  logic                  s_last,
    output logic [N*B-1:0]        feat_vec,
    input  logic [kw_of(C)-1:0]   klass_in,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [kw_of(C)-1:0]   res_klass,
    output logic                  err_frame
);

    localparam int KW = kw_of(C);
    localparam int IW = idx_w_of(N);
    localparam int CW = cnt_w_of(Ts);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(Ts - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          run;
    logic          accept;
    logic          wr_en;
    logic          klass_ld;
    logic          err_nxt;

    // run holds s_ready low while in reset and for the edge that releases it.
    assign s_ready   = run && ((state == LOAD) || (state == DRAIN));
    assign accept    = s_valid && s_ready;
    assign res_valid = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        wr_en     = 1'b0;
        klass_ld  = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_nxt = '0;
                        if (s_last) begin
                            cnt_nxt   = '0;
                            state_nxt = SETTLE;
                        end else begin
                            // Over-long frame: swallow the rest up to s_last.
                            err_nxt   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (s_last) begin
                        err_nxt = 1'b1;
                        idx_nxt = '0;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) state_nxt = LOAD;
            end
            SETTLE: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    klass_ld  = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (res_ready) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            err_frame <= 1'b0;
            feat_vec  <= '0;
            res_klass <= '0;
        end else begin
            run       <= 1'b1;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            err_frame <= err_nxt;
            // Feature 0 lands in the MSBs of the classifier input.
            if (wr_en) feat_vec[(N - 1 - int'(idx)) * B +: B] <= s_data;
            if (klass_ld) res_klass <= klass_in;
        end
    end

endmodule
